arp_header_tx: RTL and testbench

- Transmit-side ARP engine; counterpart of the ARP receive parser.
- Serialises 28-byte ARP packets (HTYPE through TPA) as a byte stream into the Ethernet TX framer. The framer adds preamble, MAC header and CRC.
- Produces replies when the RX parser flags a valid request for our IP. Produces requests on a host trigger.
- Supplies the destination MAC the framer must place in the Ethernet header.

---
 rtl/arp_pkg.sv | 31 +++
 rtl/arp_header_tx_if.sv | 19 +
 rtl/arp_header_tx.sv | 170 +++++++++++++++++
 tb/tb_arp_header_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
// Shared ARP constants, TX state encoding and byte-select helper.
// Used by both the ARP receive parser and the transmit engine.
package arp_pkg;

  localparam logic [15:0] HTYPE     = 16'h0001;
  localparam logic [15:0] PTYPE     = 16'h0800;
  localparam logic [7:0]  HLEN      = 8'h06;
  localparam logic [7:0]  PLEN      = 8'h04;
  localparam logic [15:0] OPER_RQ   = 16'h0001;
  localparam logic [15:0] OPER_RESP = 16'h0002;
  localparam logic [47:0] MAC_Z     = 48'h0000_0000_0000;
  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SHA,
    ST_SPA,
    ST_THA,
    ST_TPA,
    ST_PAD
  } arp_tx_state_e;

  // Byte 'index' of a big-endian field that is 'nbytes' long, right-aligned in 64 bits.
  function automatic logic [7:0] get_byte(input logic [63:0] field,
                                          input logic [4:0]  index,
                                          input logic [4:0]  nbytes);
    return 8'(field >> (8 * (32'(nbytes) - 32'(index) - 1)));
  endfunction

endpackage

// File: rtl/arp_header_tx_if.sv
// Byte stream from the ARP TX engine into the Ethernet TX framer.
interface arp_header_tx_if;
  logic [7:0]  arp_tx_data;
  logic        arp_tx_valid;
  logic        arp_tx_ready;
  logic        arp_tx_last;
  logic [47:0] arp_tx_mac_d_addr;
  logic        arp_tx_busy;

  modport master (
    output arp_tx_data, arp_tx_valid, arp_tx_last, arp_tx_mac_d_addr, arp_tx_busy,
    input  arp_tx_ready
  );

  modport slave (
    input  arp_tx_data, arp_tx_valid, arp_tx_last, arp_tx_mac_d_addr, arp_tx_busy,
    output arp_tx_ready
  );
endinterface

// File: rtl/arp_header_tx.sv
// ARP transmit engine: serialises ARP replies/requests (28 bytes, or 28+PAD_LEN
// zero bytes when ARP_PAD_EN is defined) towards the Ethernet TX framer.
module arp_header_tx
  import arp_pkg::*;
#(
  parameter int PAD_LEN = 18
) (
  input  logic                   mac_gmii_tx_clk,
  input  logic                   mac_gmii_tx_rst,
  input  logic [47:0]            local_mac_addr,
  input  logic [31:0]            local_ip_addr,
  input  logic                   rq_valid,
  input  logic [47:0]            rq_mac_s_addr,
  input  logic [31:0]            rq_ip_s_addr,
  input  logic                   req_start,
  input  logic [31:0]            req_ip_d_addr,
  arp_header_tx_if.master        tx
);

  if (PAD_LEN < 0 || PAD_LEN > 31) begin : g_bad_pad_len
    $error("PAD_LEN must be in 0..31 to fit the 5-bit byte count");
  end

  arp_tx_state_e state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [4:0]    seg_len;
  arp_tx_state_e seg_next;

  logic          reply_pend_q, req_pend_q;
  logic          start_reply, start_req;
  logic          valid, hs, last;
  logic [7:0]    data;

  logic [47:0]   rq_mac_q;
  logic [31:0]   rq_ip_q;
  logic [31:0]   req_ip_q;
  logic [15:0]   f_oper_q;
  logic [47:0]   f_sha_q, f_tha_q;
  logic [31:0]   f_spa_q, f_tpa_q;
  logic [47:0]   mac_d_q;

  assign valid = (state_q != ST_IDLE);
  assign hs    = valid && tx.arp_tx_ready;

  always_ff @(posedge mac_gmii_tx_clk or posedge mac_gmii_tx_rst) begin
    if (mac_gmii_tx_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_reply = 1'b0;
    start_req   = 1'b0;
    data        = 8'h00;
    last        = 1'b0;
    seg_len     = 5'd1;
    seg_next    = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (reply_pend_q) begin
          start_reply = 1'b1;
          state_d     = ST_HDR;
        end else if (req_pend_q) begin
          start_req = 1'b1;
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        seg_len  = 5'd8;
        seg_next = ST_SHA;
        data     = get_byte({HTYPE, PTYPE, HLEN, PLEN, f_oper_q}, cnt_q, 5'd8);
      end
      ST_SHA: begin
        seg_len  = 5'd6;
        seg_next = ST_SPA;
        data     = get_byte({16'h0, f_sha_q}, cnt_q, 5'd6);
      end
      ST_SPA: begin
        seg_len  = 5'd4;
        seg_next = ST_THA;
        data     = get_byte({32'h0, f_spa_q}, cnt_q, 5'd4);
      end
      ST_THA: begin
        seg_len  = 5'd6;
        seg_next = ST_TPA;
        data     = get_byte({16'h0, f_tha_q}, cnt_q, 5'd6);
      end
      ST_TPA: begin
        seg_len = 5'd4;
        data    = get_byte({32'h0, f_tpa_q}, cnt_q, 5'd4);
`ifdef ARP_PAD_EN
        seg_next = (PAD_LEN == 0) ? ST_IDLE : ST_PAD;
        last     = (PAD_LEN == 0) && (cnt_q == 5'd3);
`else
        seg_next = ST_IDLE;
        last     = (cnt_q == 5'd3);
`endif
      end
`ifdef ARP_PAD_EN
      ST_PAD: begin
        seg_len  = 5'(PAD_LEN);
        seg_next = ST_IDLE;
        last     = (cnt_q == 5'(PAD_LEN - 1));
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Bytes advance only on an accepted handshake; count restarts per field.
    if (hs) begin
      if (cnt_q == seg_len - 5'd1) begin
        state_d = seg_next;
        cnt_d   = 5'd0;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  // Pending flags: a pulse in the cycle its flag is consumed wins over the clear.
  always_ff @(posedge mac_gmii_tx_clk or posedge mac_gmii_tx_rst) begin
    if (mac_gmii_tx_rst) begin
      reply_pend_q <= 1'b0;
      req_pend_q   <= 1'b0;
      mac_d_q      <= 48'h0;
    end else begin
      if (start_reply) reply_pend_q <= 1'b0;
      if (rq_valid)    reply_pend_q <= 1'b1;
      if (start_req)   req_pend_q   <= 1'b0;
      if (req_start)   req_pend_q   <= 1'b1;
      if (start_reply)    mac_d_q <= rq_mac_q;
      else if (start_req) mac_d_q <= MAC_BCAST;
    end
  end

  // Captured pulse fields and the per-frame snapshot; gated by control, no reset needed.
  always_ff @(posedge mac_gmii_tx_clk) begin
    if (rq_valid) begin
      rq_mac_q <= rq_mac_s_addr;
      rq_ip_q  <= rq_ip_s_addr;
    end
    if (req_start) req_ip_q <= req_ip_d_addr;
    if (start_reply) begin
      f_oper_q <= OPER_RESP;
      f_sha_q  <= local_mac_addr;
      f_spa_q  <= local_ip_addr;
      f_tha_q  <= rq_mac_q;
      f_tpa_q  <= rq_ip_q;
    end else if (start_req) begin
      f_oper_q <= OPER_RQ;
      f_sha_q  <= local_mac_addr;
      f_spa_q  <= local_ip_addr;
      f_tha_q  <= MAC_Z;
      f_tpa_q  <= req_ip_q;
    end
  end

  assign tx.arp_tx_valid      = valid;
  assign tx.arp_tx_busy       = valid;
  assign tx.arp_tx_data       = data;
  assign tx.arp_tx_last       = last;
  assign tx.arp_tx_mac_d_addr = mac_d_q;

endmodule

// File: tb/tb_arp_header_tx.sv
// Directed self-checking bench for arp_header_tx (honours ARP_PAD_EN).
module tb_arp_header_tx;

`ifdef ARP_PAD_EN
  localparam int FLEN = 46;
`else
  localparam int FLEN = 28;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] local_mac;
  logic [31:0] local_ip;
  logic        rq_valid;
  logic [47:0] rq_mac;
  logic [31:0] rq_ip;
  logic        req_start;
  logic [31:0] req_ip;

  arp_header_tx_if tif ();

  arp_header_tx #(.PAD_LEN(18)) dut (
    .mac_gmii_tx_clk (clk),
    .mac_gmii_tx_rst (rst),
    .local_mac_addr  (local_mac),
    .local_ip_addr   (local_ip),
    .rq_valid        (rq_valid),
    .rq_mac_s_addr   (rq_mac),
    .rq_ip_s_addr    (rq_ip),
    .req_start       (req_start),
    .req_ip_d_addr   (req_ip),
    .tx              (tif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  reply_vec [28] = '{
    8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02,
    8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h01, 8'h0A,
    8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'hC0, 8'hA8, 8'h01, 8'h05};

  logic [7:0]  got [64];
  logic [7:0]  exp_b [46];
  int          got_n, got_last, first_cyc;
  logic [47:0] got_dmac;
  logic [47:0] inj_mac, inj_local;
  logic [31:0] inj_ip;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void build_exp(input logic [15:0] oper, input logic [47:0] sha,
                                    input logic [31:0] spa, input logic [47:0] tha,
                                    input logic [31:0] tpa);
    logic [223:0] v;
    v = {16'h0001, 16'h0800, 8'h06, 8'h04, oper, sha, spa, tha, tpa};
    for (int i = 0; i < 28; i++) exp_b[i] = v[223 - 8*i -: 8];
    for (int i = 28; i < 46; i++) exp_b[i] = 8'h00;
  endfunction

  function automatic void reply_exp();
    for (int i = 0; i < 46; i++) exp_b[i] = (i < 28) ? reply_vec[i] : 8'h00;
  endfunction

  task automatic pulse_rq(input logic [47:0] mac, input logic [31:0] ip);
    @(negedge clk);
    rq_valid = 1'b1; rq_mac = mac; rq_ip = ip;
    @(negedge clk);
    rq_valid = 1'b0;
  endtask

  task automatic pulse_req(input logic [31:0] ip);
    @(negedge clk);
    req_start = 1'b1; req_ip = ip;
    @(negedge clk);
    req_start = 1'b0;
  endtask

  // Collects one frame; optional random backpressure, mid-frame rq_valid injection or reset.
  task automatic get_frame(input bit bp, input int inj_at, input int rst_at);
    bit         held, injected, done;
    logic [7:0] hd;
    logic       hl;
    got_n = 0; got_last = -1; first_cyc = -1;
    held = 0; injected = 0; done = 0; hd = 8'h00; hl = 1'b0;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      @(negedge clk);
      if (rq_valid) rq_valid = 1'b0;
      tif.arp_tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rst_at >= 0 && got_n == rst_at && tif.arp_tx_valid) begin
        rst = 1'b1;
        #1;
        chk("rst_valid", 64'(tif.arp_tx_valid), 64'(0));
        chk("rst_busy", 64'(tif.arp_tx_busy), 64'(0));
        chk("rst_last", 64'(tif.arp_tx_last), 64'(0));
        chk("rst_data", 64'(tif.arp_tx_data), 64'(0));
        chk("rst_dmac", 64'(tif.arp_tx_mac_d_addr), 64'(0));
        return;
      end
      if (tif.arp_tx_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          got_dmac  = tif.arp_tx_mac_d_addr;
        end else begin
          chk("dmac_stable", 64'(tif.arp_tx_mac_d_addr), 64'(got_dmac));
        end
        chk("busy", 64'(tif.arp_tx_busy), 64'(1));
        if (held) begin
          chk("hold_data", 64'(tif.arp_tx_data), 64'(hd));
          chk("hold_last", 64'(tif.arp_tx_last), 64'(hl));
        end
        if (inj_at >= 0 && !injected && got_n == inj_at) begin
          rq_valid = 1'b1; rq_mac = inj_mac; rq_ip = inj_ip;
          local_mac = inj_local;
          injected = 1;
        end
        if (tif.arp_tx_ready) begin
          got[got_n] = tif.arp_tx_data;
          if (tif.arp_tx_last) begin
            got_last = got_n;
            done = 1;
          end
          got_n++;
          held = 0;
        end else begin
          held = 1;
          hd = tif.arp_tx_data;
          hl = tif.arp_tx_last;
        end
      end
    end
    rq_valid = 1'b0;
    chk("frame_done", 64'(done), 64'(1));
  endtask

  task automatic check_frame(input string nm, input logic [47:0] dmac_exp);
    chk({nm, "_len"}, 64'(got_n), 64'(FLEN));
    chk({nm, "_last_idx"}, 64'(got_last), 64'(FLEN - 1));
    chk({nm, "_dmac"}, 64'(got_dmac), 64'(dmac_exp));
    for (int i = 0; i < FLEN; i++)
      chk($sformatf("%s_byte%0d", nm, i), 64'(got[i]), 64'(exp_b[i]));
  endtask

  initial begin
    rst = 1'b1;
    local_mac = 48'h02_00_00_00_00_01;
    local_ip  = 32'hC0A8010A;
    rq_valid = 1'b0; rq_mac = '0; rq_ip = '0;
    req_start = 1'b0; req_ip = '0;
    tif.arp_tx_ready = 1'b0;
    inj_mac = 48'h0A_0B_0C_0D_0E_0F; inj_ip = 32'hC0A80165;
    inj_local = 48'h02_00_00_00_00_99;

    repeat (2) @(negedge clk);
    chk("reset_valid", 64'(tif.arp_tx_valid), 64'(0));
    chk("reset_busy", 64'(tif.arp_tx_busy), 64'(0));
    chk("reset_last", 64'(tif.arp_tx_last), 64'(0));
    chk("reset_data", 64'(tif.arp_tx_data), 64'(0));
    chk("reset_dmac", 64'(tif.arp_tx_mac_d_addr), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", 64'(tif.arp_tx_valid), 64'(0));

    // Reply, ready held high
    pulse_rq(48'h10_20_30_40_50_60, 32'hC0A80105);
    chk("lat_still_idle", 64'(tif.arp_tx_valid), 64'(0));
    get_frame(0, -1, -1);
    chk("reply_latency", 64'(first_cyc), 64'(1));
    reply_exp();
    check_frame("reply", 48'h10_20_30_40_50_60);
    @(negedge clk);
    chk("eof_valid", 64'(tif.arp_tx_valid), 64'(0));
    chk("eof_busy", 64'(tif.arp_tx_busy), 64'(0));

    // Request
    pulse_req(32'hC0A80101);
    get_frame(0, -1, -1);
    build_exp(16'h0001, local_mac, local_ip, 48'h0, 32'hC0A80101);
    check_frame("request", 48'hFFFF_FFFF_FFFF);

    // Reply under random backpressure
    pulse_rq(48'h10_20_30_40_50_60, 32'hC0A80105);
    get_frame(1, -1, -1);
    reply_exp();
    check_frame("bp_reply", 48'h10_20_30_40_50_60);

    // Collision plus mid-frame rq_valid and local MAC change
    @(negedge clk);
    rq_valid = 1'b1; rq_mac = 48'hAA_BB_CC_DD_EE_FF; rq_ip = 32'hC0A80164;
    req_start = 1'b1; req_ip = 32'hC0A80102;
    @(negedge clk);
    rq_valid = 1'b0; req_start = 1'b0;
    get_frame(0, 10, -1);
    build_exp(16'h0002, 48'h02_00_00_00_00_01, 32'hC0A8010A, 48'hAA_BB_CC_DD_EE_FF, 32'hC0A80164);
    check_frame("col_reply", 48'hAA_BB_CC_DD_EE_FF);
    get_frame(0, -1, -1);
    chk("col_gap1", 64'(first_cyc), 64'(2));
    build_exp(16'h0002, inj_local, 32'hC0A8010A, inj_mac, inj_ip);
    check_frame("col_reply2", inj_mac);
    get_frame(0, -1, -1);
    chk("col_gap2", 64'(first_cyc), 64'(2));
    build_exp(16'h0001, inj_local, 32'hC0A8010A, 48'h0, 32'hC0A80102);
    check_frame("col_request", 48'hFFFF_FFFF_FFFF);

    // Reset at byte 12, then a clean frame
    local_mac = 48'h02_00_00_00_00_01;
    pulse_rq(48'h10_20_30_40_50_60, 32'hC0A80105);
    get_frame(0, -1, 12);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", 64'(tif.arp_tx_valid), 64'(0));
    chk("post_rst_busy", 64'(tif.arp_tx_busy), 64'(0));
    pulse_rq(48'h10_20_30_40_50_60, 32'hC0A80105);
    get_frame(0, -1, -1);
    reply_exp();
    check_frame("rst_reply", 48'h10_20_30_40_50_60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
